// File: rtl/mult_seq_ctrl_pkg.sv
// Shared ALU control codes and multiply
// sequencer state encoding for the EX stage.
package mult_seq_ctrl_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLTI = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_ADDI = 4'b1000;
  localparam logic [3:0] ALU_BEQ  = 4'b1010;
  localparam logic [3:0] ALU_MUL  = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_seq_ctrl_dp.sv
// Radix-2 shift-add datapath: accumulator,
// multiplicand and multiplier registers.
module shift_add_dp #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic [WIDTH-1:0] acc_next,
  output logic             mplier_zero
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;

  always_comb begin
    acc_next = mplier[0] ? acc + mcand : acc;
    // zero test is on the multiplier after this step's shift
    mplier_zero = (mplier[WIDTH-1:1] == '0);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= src1;
      mplier <= src2;
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// EX-stage multi-cycle multiply sequencer:
// stalls the pipeline until the product is ready.
module mult_seq_ctrl
  import mult_seq_ctrl_pkg::*;
#(
  parameter int         WIDTH      = 32,
  parameter logic [3:0] MULT_CODE  = ALU_MUL,
  parameter bit         EARLY_EXIT = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             abort_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            req;
  logic            load;
  logic            step;
  logic            finish;
  logic [WIDTH-1:0] acc_next;
  logic            mplier_zero;

  always_comb begin
    req    = valid_i && (ALUCtrl_i == MULT_CODE) && !abort_i;
    load   = (state == IDLE) && req;
    step   = (state == RUN) && !abort_i;
    finish = (cnt == LAST) || (EARLY_EXIT && mplier_zero);
  end

  // gated by reset so the held request cannot stall during reset
  always_comb begin
    stall_o = 1'b0;
    unique case (state)
      IDLE:    stall_o = req && rst_i;
      RUN:     stall_o = 1'b1;
      default: stall_o = 1'b0;
    endcase
  end

  assign busy_o = (state == RUN);

  shift_add_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load       (load),
    .step       (step),
    .src1       (src1_i),
    .src2       (src2_i),
    .acc_next   (acc_next),
    .mplier_zero(mplier_zero)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      done_o   <= 1'b0;
      result_o <= '0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (abort_i) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            if (finish) begin
              state    <= DONE;
              done_o   <= 1'b1;
              result_o <= acc_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl with
// directed and random multiplies vs. an arithmetic model.
module tb_mult_seq_ctrl;
  import mult_seq_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        valid_ee = 1'b0;
  logic [3:0]  alu = 4'b0000;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        abort = 1'b0;

  logic        stall, busy, done;
  logic [31:0] result;
  logic        stall_ee, busy_ee, done_ee;
  logic [31:0] result_ee;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  mult_seq_ctrl #(.WIDTH(32), .MULT_CODE(4'b1100), .EARLY_EXIT(1'b0)) dut (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .ALUCtrl_i(alu),
    .src1_i(src1), .src2_i(src2), .abort_i(abort),
    .stall_o(stall), .busy_o(busy), .done_o(done), .result_o(result)
  );

  mult_seq_ctrl #(.WIDTH(32), .MULT_CODE(4'b1100), .EARLY_EXIT(1'b1)) dut_ee (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid_ee), .ALUCtrl_i(alu),
    .src1_i(src1), .src2_i(src2), .abort_i(abort),
    .stall_o(stall_ee), .busy_o(busy_ee), .done_o(done_ee),
    .result_o(result_ee)
  );

  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbits(input logic [31:0] b);
    int n = 0;
    logic [31:0] t = b;
    while (t != 0) begin
      t = t >> 1;
      n++;
    end
    return n;
  endfunction

  function automatic logic st(input bit ee);
    return ee ? stall_ee : stall;
  endfunction
  function automatic logic dn(input bit ee);
    return ee ? done_ee : done;
  endfunction
  function automatic logic bz(input bit ee);
    return ee ? busy_ee : busy;
  endfunction
  function automatic logic [31:0] rs(input bit ee);
    return ee ? result_ee : result;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered just after a rising edge; returns at the negedge of DONE.
  task automatic do_mult(input bit ee, input logic [31:0] a,
                         input logic [31:0] b, input string tag);
    logic [31:0] exp_p;
    int lat;
    int cyc = 0;
    bit seen = 0;
    bit stall_bad = 0;
    exp_p = a * b;
    lat = ee ? (((nbits(b) == 0) ? 1 : nbits(b)) + 1) : 33;
    src1 = a;
    src2 = b;
    alu = ALU_MUL;
    if (ee) valid_ee = 1'b1;
    else valid = 1'b1;
    @(negedge clk);
    if (st(ee) !== 1'b1) stall_bad = 1;
    while (!seen && cyc < 100) begin
      step();
      src1 = $urandom;
      src2 = $urandom;
      cyc++;
      @(negedge clk);
      if (dn(ee) === 1'b1) seen = 1;
      else if (st(ee) !== 1'b1) stall_bad = 1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, cyc, lat);
    chk({tag, "_result"}, rs(ee), exp_p);
    chk({tag, "_stall_in_done"}, 32'(st(ee)), 32'd0);
    chk({tag, "_busy_in_done"}, 32'(bz(ee)), 32'd0);
    chk({tag, "_stall_while_run"}, 32'(stall_bad), 32'd0);
  endtask

  initial begin
    logic [31:0] prev;
    logic [31:0] ra, rb;
    int d0;
    bit extra;

    #12;
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    do_mult(0, 32'd7, 32'd6, "m7x6");
    step();
    valid = 1'b0;
    do_mult(0, 32'hFFFF_FFFD, 32'd5, "neg3x5");
    step();
    valid = 1'b0;
    do_mult(0, 32'h0001_0000, 32'h0001_0000, "wrap");
    step();
    valid = 1'b0;
    step();

    // back-to-back, request held through both DONE cycles
    d0 = done_cnt;
    do_mult(0, 32'd3, 32'd4, "b2b_a");
    step();
    do_mult(0, 32'd5, 32'd5, "b2b_b");
    step();
    chk("b2b_no_restart_busy", 32'(busy), 32'd0);
    chk("b2b_no_restart_done", 32'(done), 32'd0);
    valid = 1'b0;
    step();
    step();
    chk("b2b_pulse_count", done_cnt - d0, 32'd2);

    // non-multiply operation
    valid = 1'b1;
    alu = ALU_ADD;
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (stall !== 1'b0 || busy !== 1'b0 || done !== 1'b0) extra = 1;
      step();
    end
    chk("nonmult_idle", 32'(extra), 32'd0);
    valid = 1'b0;

    // abort in IDLE suppresses the start
    valid = 1'b1;
    alu = ALU_MUL;
    abort = 1'b1;
    @(negedge clk);
    chk("abort_idle_stall", 32'(stall), 32'd0);
    step();
    valid = 1'b0;
    abort = 1'b0;
    chk("abort_idle_busy", 32'(busy), 32'd0);

    // 9x9 aborted in cycle 10
    prev = result;
    d0 = done_cnt;
    valid = 1'b1;
    src1 = 32'd9;
    src2 = 32'd9;
    for (int c = 1; c <= 10; c++) step();
    abort = 1'b1;
    valid = 1'b0;
    step();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_stall", 32'(stall), 32'd0);
    for (int i = 0; i < 40; i++) step();
    chk("abort_no_done", done_cnt - d0, 32'd0);
    chk("abort_result_kept", result, prev);

    // asynchronous reset in cycle 15 of a run
    valid = 1'b1;
    src1 = 32'd9;
    src2 = 32'd9;
    for (int c = 1; c <= 15; c++) step();
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_stall", 32'(stall), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    chk("async_rst_result", result, 32'd0);
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // random operands
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      do_mult(0, ra, rb, $sformatf("rnd%0d", i));
      step();
      valid = 1'b0;
    end

    // early-exit instance
    do_mult(1, 32'd3, 32'd2, "ee3x2");
    step();
    valid_ee = 1'b0;
    do_mult(1, 32'd11, 32'd0, "ee_zero");
    step();
    valid_ee = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ra = $urandom;
      rb = $urandom_range(0, 4095);
      do_mult(1, ra, rb, $sformatf("ee_rnd%0d", i));
      step();
      valid_ee = 1'b0;
    end
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Multi-cycle sequencer for the EX-stage multiply operation (ALU control code 4'b1100).
- Runs a radix-2 shift-add multiply over several cycles, holding the pipeline with a stall until the product is ready.
- Non-multiply ALU operations pass the EX stage untouched; this block is idle for them.
- Sits beside the ALU in EX. stall_o feeds the PC, IF/ID and ID/EX hold logic; result_o feeds the EX result mux.

Parameters:
- WIDTH, 32, operand and result width.
- MULT_CODE, 4'b1100, ALU control code that requests a multiply.
- EARLY_EXIT, 0, when 1 the block finishes as soon as the remaining multiplier bits are all zero.

Ports:
- clk_i  input  1  clock. One clock; reset is asynchronous and active-low.
- rst_i  input  1  asynchronous active-low reset.
- valid_i  input  1  the EX stage holds a valid instruction.
- ALUCtrl_i  input  4  ALU control code of the instruction in EX.
- src1_i  input  WIDTH  multiplicand.
- src2_i  input  WIDTH  multiplier.
- abort_i  input  1  synchronous cancel of the in-flight multiply (flush).
- stall_o  output  1  hold the PC, IF/ID and ID/EX registers.
- busy_o  output  1  state is RUN.
- done_o  output  1  one-cycle pulse; the product is valid.
- result_o  output  WIDTH  low WIDTH bits of src1 times src2.

Behaviour:
- Reset values: state IDLE; all outputs 0; internal accumulator, multiplicand, multiplier and counter are 0.
- Reset is asynchronous. Asserting it mid-operation drops stall_o, busy_o and done_o in the same cycle, without waiting for a clock edge.
- req = valid_i && (ALUCtrl_i == MULT_CODE) && !abort_i.
- IDLE state:
  - stall_o = req (combinational).
  - On req, latch src1_i and src2_i, clear the accumulator and counter, then go to RUN.
- RUN state:
  - stall_o = 1 and busy_o = 1.
  - Each cycle: if the multiplier LSB is 1, add the multiplicand to the accumulator (mod 2^WIDTH). Then shift the multiplicand left by 1, shift the multiplier right by 1, and increment the counter.
  - Go to DONE when the counter equals WIDTH-1, or when EARLY_EXIT=1 and the shifted multiplier is 0.
- DONE state (one cycle):
  - done_o = 1 and stall_o = 0, so the held instruction advances with result_o valid.
  - Always return to IDLE. The still-present request is ignored, so the instruction is not executed twice.
- result_o:
  - Registered; loaded from the final accumulator on entry to DONE.
  - Holds its value until the next completed multiply. It is not cleared on abort.
- Latency: request seen in cycle 0; RUN covers cycles 1..WIDTH; DONE occurs in cycle WIDTH+1. stall_o is high for WIDTH+1 cycles.
- Arithmetic is unsigned shift-add. The low WIDTH bits are therefore correct for two's-complement operands; the upper half is discarded (overflow wraps).
- abort_i:
  - Highest priority after reset.
  - In RUN or DONE, go to IDLE at the next edge with no done_o pulse.
  - In IDLE it suppresses the start, and stall_o is 0.
- Back-to-back multiplies: a second multiply reaches EX in the cycle after DONE and starts from IDLE normally. There is one bubble-free handoff.
- Operand changes on src1_i/src2_i during RUN are ignored, because the operands are latched.

Decomposition:
- Shared package holds:
  - the ALU control code constants (add 4'b0010, sub 4'b0110, and 4'b0000, or 4'b0001, slt 4'b0111, mult 4'b1100, addi 4'b1000, slti 4'b0101, beq 4'b1010);
  - the state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- One sub-module, shift_add_dp: accumulator, multiplicand and multiplier registers plus the adder. Its controls are load/step.
- The FSM, counter and stall logic stay in mult_seq_ctrl.

Test Plan:
- 7 x 6: valid_i=1, ALUCtrl_i=4'b1100 -> stall_o high for cycles 0..32; done_o in cycle 33; result_o=42; stall_o=0 in cycle 33.
- 0xFFFFFFFD x 5 -> result_o=0xFFFFFFF1 (-15). Then 0x00010000 x 0x00010000 -> result_o=0 (wrap).
- Two multiplies back-to-back (3x4, then 5x5): done_o pulses in cycles 33 and 67 with results 12 and 25. Exactly two done_o pulses occur, with no restart in either DONE cycle.
- Non-mult op (ALUCtrl_i=4'b0010, valid_i=1) -> stall_o=0, busy_o=0, state stays IDLE.
- 9x9 with abort_i pulsed in cycle 10 -> IDLE in cycle 11; no done_o; result_o keeps its prior value. Separately, rst_i=0 in cycle 15 of a run -> all outputs 0 immediately.
- EARLY_EXIT=1, 3 x 2 -> RUN in cycles 1-2; done_o in cycle 3; result_o=6.
